// File: rtl/bus_arb_pkg.sv
// Shared constants, state encodings and index helper for the bus source arbiter.
// State TURN exists only when BUS_ARB_TURNAROUND_EN is defined.
package bus_arb_pkg;

    localparam int unsigned NUM_SRC  = 24;
    localparam int unsigned SEL_W    = 5;
    localparam int unsigned MAX_HOLD = 4;
    localparam int unsigned HOLD_W   = $clog2(MAX_HOLD);
    localparam int unsigned ST_W     = 2;

    localparam int unsigned SRC_R0     = 0;
    localparam int unsigned SRC_R15    = 15;
    localparam int unsigned SRC_HI     = 16;
    localparam int unsigned SRC_LO     = 17;
    localparam int unsigned SRC_ZHI    = 18;
    localparam int unsigned SRC_ZLO    = 19;
    localparam int unsigned SRC_PC     = 20;
    localparam int unsigned SRC_MDR    = 21;
    localparam int unsigned SRC_INPORT = 22;
    localparam int unsigned SRC_C      = 23;

    localparam logic [SEL_W-1:0] SEL_NONE = 5'h1F;

    localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [ST_W-1:0] ST_GRANTED = 2'd1;
`ifdef BUS_ARB_TURNAROUND_EN
    localparam logic [ST_W-1:0] ST_TURN    = 2'd2;
`endif

    // Source index base+offs, wrapping past the last source back to 0.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                  input int unsigned offs);
        int unsigned sum;
        sum = 32'(base) + offs;
        if (sum >= NUM_SRC) sum = sum - NUM_SRC;
        return SEL_W'(sum);
    endfunction

endpackage

// File: rtl/bus_source_arbiter_if.sv
// Request/grant bundle between the control unit (master) and the arbiter (slave).
interface bus_source_arbiter_if;
    import bus_arb_pkg::*;

    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] grant;
    logic               grant_valid;
    logic [SEL_W-1:0]   bus_sel;
    logic               busy;

    modport master (output req, input grant, input grant_valid, input bus_sel, input busy);
    modport slave  (input req, output grant, output grant_valid, output bus_sel, output busy);

endinterface

// File: rtl/bus_rr_picker.sv
// Combinational round-robin pick: first set req bit scanning upward from ptr with wrap.
module bus_rr_picker
    import bus_arb_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   index,
    output logic               found
);

    always_comb begin
        index = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!found && req[wrap_add(ptr, k)]) begin
                index = wrap_add(ptr, k);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_source_arbiter.sv
// Round-robin owner arbiter for the shared datapath bus with a bounded hold time.
// Define BUS_ARB_TURNAROUND_EN to insert one idle TURN cycle after every release.
module bus_source_arbiter
    import bus_arb_pkg::*;
(
    input  logic                 clock,
    input  logic                 clear,
    bus_source_arbiter_if.slave  bus
);

    logic [ST_W-1:0]    state, state_n;
    logic [SEL_W-1:0]   ptr, ptr_n;
    logic [HOLD_W-1:0]  hold_cnt, hold_n;
    logic [SEL_W-1:0]   sel_n;
    logic [NUM_SRC-1:0] grant_n;
    logic [SEL_W-1:0]   pick_ptr;
    logic [SEL_W-1:0]   pick_idx;
    logic               pick_found;
    logic               others;
    logic               keep;

    // While granted, the scan for a successor starts just past the current owner.
    assign pick_ptr = (state == ST_GRANTED) ? wrap_add(bus.bus_sel, 1) : ptr;
    assign others   = |(bus.req & ~bus.grant);

    bus_rr_picker u_picker (
        .req   (bus.req),
        .ptr   (pick_ptr),
        .index (pick_idx),
        .found (pick_found)
    );

    // Next-state, next-output decode.
    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        hold_n  = hold_cnt;
        sel_n   = bus.bus_sel;
        grant_n = bus.grant;
        keep    = 1'b0;

        case (state)
            ST_GRANTED: begin
                keep = bus.req[bus.bus_sel] &&
                       ((hold_cnt < HOLD_W'(MAX_HOLD - 1)) || !others);
                if (keep) begin
                    if (hold_cnt < HOLD_W'(MAX_HOLD - 1)) hold_n = hold_cnt + HOLD_W'(1);
                end else begin
                    ptr_n = pick_ptr;
`ifdef BUS_ARB_TURNAROUND_EN
                    state_n = ST_TURN;
                    grant_n = '0;
                    sel_n   = SEL_NONE;
                    hold_n  = '0;
`else
                    if (pick_found) begin
                        state_n = ST_GRANTED;
                        sel_n   = pick_idx;
                        grant_n = NUM_SRC'(1) << pick_idx;
                        hold_n  = '0;
                    end else begin
                        state_n = ST_IDLE;
                        grant_n = '0;
                        sel_n   = SEL_NONE;
                        hold_n  = '0;
                    end
`endif
                end
            end
`ifdef BUS_ARB_TURNAROUND_EN
            ST_IDLE, ST_TURN: begin
`else
            ST_IDLE: begin
`endif
                hold_n = '0;
                if (pick_found) begin
                    state_n = ST_GRANTED;
                    sel_n   = pick_idx;
                    grant_n = NUM_SRC'(1) << pick_idx;
                end else begin
                    state_n = ST_IDLE;
                    grant_n = '0;
                    sel_n   = SEL_NONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                grant_n = '0;
                sel_n   = SEL_NONE;
                hold_n  = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state           <= ST_IDLE;
            ptr             <= '0;
            hold_cnt        <= '0;
            bus.grant       <= '0;
            bus.grant_valid <= 1'b0;
            bus.bus_sel     <= SEL_NONE;
            bus.busy        <= 1'b0;
        end else begin
            state           <= state_n;
            ptr             <= ptr_n;
            hold_cnt        <= hold_n;
            bus.grant       <= grant_n;
            bus.grant_valid <= |grant_n;
            bus.bus_sel     <= sel_n;
            bus.busy        <= (state_n != ST_IDLE);
        end
    end

endmodule
